halfband_decim_mac_scheduler: RTL and testbench

- Decimate-by-2 halfband FIR controller that time-shares one pre-add/multiply/accumulate datapath across all nonzero taps.
- It holds the sample delay line, decides which input samples trigger an output, and sequences the shared MAC through the symmetric tap pairs plus the center tap.
- It emits one rounded, saturated output through a valid/ready handshake.
- It sits between the sample source and the downstream polyphase stages.

---
 rtl/polyphase_pkg.sv | 32 +++
 rtl/sym_preadd_mac.sv | 53 +++++
 rtl/halfband_decim_mac_scheduler.sv | 167 ++++++++++++++++
 tb/tb_halfband_decim_mac_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polyphase_pkg.sv
// Shared types and helpers for the halfband decimator controller and its MAC.
// Latency: none (package of constants, the FSM state type and a pure function).
// Backpressure: not applicable.
package polyphase_pkg;

  // Default geometry: 8 symmetric even-tap pairs, centre tap at index 15.
  localparam int NPAIRS = 8;
  localparam int C      = 2 * NPAIRS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Round half up, arithmetic shift right, then clamp to a signed width-bit range.
  function automatic longint round_sat(input longint acc, input int shift, input int width);
    longint v;
    longint hi;
    longint lo;
    v  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/sym_preadd_mac.sv
// Symmetric pre-add, multiply and accumulate with one product register in front of the accumulator.
// Latency: a product issued with i_en lands in o_acc two edges later.
// Backpressure: none; the controller owns sequencing through i_en and i_clr.
module sym_preadd_mac #(
  parameter int SAMPLE_WIDTH = 6,
  parameter int COEF_WIDTH   = 16,
  parameter int ACC_WIDTH    = 28
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_clr,
  input  logic                          i_en,
  input  logic signed [SAMPLE_WIDTH-1:0] i_a,
  input  logic signed [SAMPLE_WIDTH-1:0] i_b,
  input  logic signed [COEF_WIDTH-1:0]   i_coef,
  output logic signed [ACC_WIDTH-1:0]    o_acc
);

  localparam int PRE_W  = SAMPLE_WIDTH + 1;
  localparam int PROD_W = PRE_W + COEF_WIDTH;

  logic signed [PRE_W-1:0]  w_pre;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_prod_vld;
  logic signed [ACC_WIDTH-1:0] r_acc;

  // The pre-add is one bit wider than a sample so the pair sum cannot overflow.
  assign w_pre  = PRE_W'(i_a) + PRE_W'(i_b);
  assign w_prod = PROD_W'(w_pre) * PROD_W'(i_coef);

  // Register the product, then fold it into the accumulator on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_prod_vld <= i_en & ~i_clr;
      if (i_en) begin
        r_prod <= w_prod;
      end
      if (i_clr) begin
        r_acc <= '0;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + ACC_WIDTH'(r_prod);
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/halfband_decim_mac_scheduler.sv
// Decimate-by-2 halfband FIR controller sharing one pre-add/MAC over the symmetric pairs and centre tap.
// Latency: valid_out rises NPAIRS+2 clocks after the triggering accept edge.
// Backpressure: ready_in is low outside IDLE; the output is held until ready_out.
module halfband_decim_mac_scheduler
  import polyphase_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 6,
  parameter int TAPS         = 2 * C + 1,
  parameter int COEF_WIDTH   = 16,
  parameter int COEFS [(TAPS+1)/4] = '{-9, 27, -69, 151, -296, 560, -1108, 8936},
  parameter int CENTER_COEF  = 16384,
  parameter int OUT_SHIFT    = 15,
  parameter int ACC_WIDTH    = 28
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic signed [SAMPLE_WIDTH-1:0] data_in,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic signed [SAMPLE_WIDTH-1:0] data_out,
  output logic                           busy
);

  localparam int P_NPAIRS = (TAPS + 1) / 4;
  localparam int P_C      = (TAPS - 1) / 2;
  localparam int IDX_W    = $clog2(P_NPAIRS + 1);
  localparam int FILL_W   = $clog2(TAPS + 1);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic signed [SAMPLE_WIDTH-1:0] r_x [TAPS];
  logic [FILL_W-1:0]              r_fill;
  logic [FILL_W-1:0]              w_fill_nxt;
  logic                           r_phase;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_vld;
  logic                           w_accept;
  logic                           w_trig;
  logic                           w_mac_clr;
  logic                           w_mac_en;
  logic signed [SAMPLE_WIDTH-1:0] w_op_a;
  logic signed [SAMPLE_WIDTH-1:0] w_op_b;
  logic signed [COEF_WIDTH-1:0]   w_coef;
  logic signed [ACC_WIDTH-1:0]    w_acc;

  assign ready_in   = (r_state == IDLE);
  assign w_accept   = valid_in && ready_in;
  assign w_fill_nxt = (r_fill == FILL_W'(TAPS)) ? r_fill : r_fill + 1'b1;
  // Phase after the accept is the inverse of the current phase, so trigger on current phase 0.
  assign w_trig     = w_accept && (w_fill_nxt == FILL_W'(TAPS)) && !r_phase;

  // Delay line, fill count and decimation phase advance only on accepted samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
      end
      r_fill  <= '0;
      r_phase <= 1'b0;
    end else if (w_accept) begin
      r_x[0] <= data_in;
      for (int k = 1; k < TAPS; k++) begin
        r_x[k] <= r_x[k-1];
      end
      r_fill  <= w_fill_nxt;
      r_phase <= ~r_phase;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus MAC clear/enable: clear on the trigger, one product per MAC cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_mac_clr   = 1'b0;
    w_mac_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_nxt = MAC;
          w_mac_clr   = 1'b1;
        end
      end
      MAC: begin
        w_mac_en = 1'b1;
        if (r_idx == IDX_W'(P_NPAIRS)) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (r_vld && ready_out) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pair index walks 0..NPAIRS during MAC; the last step is the centre tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
    end else if (w_mac_clr) begin
      r_idx <= '0;
    end else if (r_state == MAC) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Operand select: symmetric pair for idx < NPAIRS, centre tap alone otherwise.
  always_comb begin
    w_op_a = r_x[P_C];
    w_op_b = '0;
    w_coef = COEF_WIDTH'(CENTER_COEF);
    for (int i = 0; i < P_NPAIRS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_op_a = r_x[2*i];
        w_op_b = r_x[TAPS-1-2*i];
        w_coef = COEF_WIDTH'(COEFS[i]);
      end
    end
  end

  sym_preadd_mac #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .COEF_WIDTH   (COEF_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_mac_clr),
    .i_en   (w_mac_en),
    .i_a    (w_op_a),
    .i_b    (w_op_b),
    .i_coef (w_coef),
    .o_acc  (w_acc)
  );

  // The first OUT cycle lets the last product drain into the accumulator, then valid rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= 1'b0;
    end else if (r_state == OUT) begin
      if (!r_vld) begin
        r_vld <= 1'b1;
      end else if (ready_out) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign valid_out = r_vld;
  assign data_out  = r_vld ? SAMPLE_WIDTH'(round_sat(longint'(w_acc), OUT_SHIFT, SAMPLE_WIDTH)) : '0;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_halfband_decim_mac_scheduler.sv
// Bench for the halfband decimator: default-coefficient and saturating-coefficient instances share stimulus.
// Latency: expected values are queued at the trigger and checked when valid_out rises.
// Backpressure: ready_out driven always-high, random, or stalled 20 cycles per output.
module tb_halfband_decim_mac_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              valid_in;
  logic              ready_out;
  logic signed [5:0] data_in;
  logic              ready_in0, valid_out0, busy0;
  logic signed [5:0] data_out0;
  logic              ready_in1, valid_out1, busy1;
  logic signed [5:0] data_out1;

  halfband_decim_mac_scheduler dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in0), .data_in(data_in),
    .valid_out(valid_out0), .ready_out(ready_out), .data_out(data_out0), .busy(busy0)
  );

  halfband_decim_mac_scheduler #(
    .COEFS('{8192, 8192, 8192, 8192, 8192, 8192, 8192, 8192}),
    .CENTER_COEF(32767)
  ) dut_sat (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in1), .data_in(data_in),
    .valid_out(valid_out1), .ready_out(ready_out), .data_out(data_out1), .busy(busy1)
  );

  typedef struct {
    int y0;
    int y1;
    int t;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;
  int   hist[$];
  exp_t exp_q[$];
  int   outs[$];
  int   h_def[31];
  int   h_sat[31];
  int   cf[8] = '{-9, 27, -69, 151, -296, 560, -1108, 8936};
  bit   held = 1'b0;
  int   held_val = 0;
  bit   idle_chk = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Direct-form convolution of the newest 31 samples, then round half up and clamp.
  function automatic int ref_y(input int h[31]);
    longint acc = 0;
    int last = hist.size() - 1;
    for (int k = 0; k < 31; k++) begin
      acc += longint'(h[k]) * longint'(hist[last-k]);
    end
    acc = (acc + 16384) >>> 15;
    if (acc > 31) acc = 31;
    if (acc < -32) acc = -32;
    return int'(acc);
  endfunction

  task automatic send(input int v);
    int waitc = 0;
    exp_t e;
    valid_in = 1'b1;
    data_in  = 6'(v);
    while (!ready_in0 && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!ready_in0) begin
      chk("send_timeout", ready_in0, 1);
      valid_in = 1'b0;
      return;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    hist.push_back(v);
    if (hist.size() >= 31 && ((hist.size() - 31) % 2) == 0) begin
      e.y0 = ref_y(h_def);
      e.y1 = ref_y(h_sat);
      e.t  = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || valid_out0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    hist.delete();
    exp_q.delete();
    outs.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // ready_out driver.
  initial begin
    int stall = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: ready_out = 1'b1;
        1: ready_out = 1'($urandom_range(0, 1));
        default: begin
          if (!valid_out0) begin
            stall = 0;
            ready_out = 1'b0;
          end else if (stall < 20) begin
            stall++;
            ready_out = 1'b0;
          end else begin
            ready_out = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: pop the expectation when valid_out rises, then check it holds until the handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        chk("idle_after_handshake", ready_in0, 1);
        chk("busy_after_handshake", busy0, 0);
        idle_chk = 1'b0;
      end
      if (valid_out0) begin
        if (!held) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", valid_out0, 0);
          end else begin
            e = exp_q.pop_front();
            chk("data_default", data_out0, e.y0);
            chk("data_saturating", data_out1, e.y1);
            chk("latency", cyc - e.t, 10);
            chk("valid_saturating", valid_out1, 1);
            outs.push_back(data_out0);
          end
          held = 1'b1;
          held_val = data_out0;
        end else begin
          chk("hold_data", data_out0, held_val);
          chk("hold_ready_in", ready_in0, 0);
        end
        if (ready_out) begin
          held = 1'b0;
          idle_chk = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int w;
    for (int k = 0; k < 31; k++) begin
      h_def[k] = 0;
      h_sat[k] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      h_def[2*i] = cf[i];
      h_def[30-2*i] = cf[i];
      h_sat[2*i] = 8192;
      h_sat[30-2*i] = 8192;
    end
    h_def[15] = 16384;
    h_sat[15] = 32767;

    reset = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_valid_out", valid_out0, 0);
    chk("rst_data_out", data_out0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ready_in", ready_in0, 1);
    chk("rst_sat_valid_out", valid_out1, 0);
    chk("rst_sat_ready_in", ready_in1, 1);

    // DC +31 and -32 with ready_out high.
    for (int n = 0; n < 80; n++) send(31);
    drain();
    chk("dc_pos_count", outs.size(), 25);
    apply_reset();
    for (int n = 0; n < 80; n++) send(-32);
    drain();
    chk("dc_neg_count", outs.size(), 25);

    // Impulses at n=45 (centre tap), 46 and 44 (innermost pair).
    apply_reset();
    for (int n = 0; n < 80; n++) send(n == 45 ? 31 : 0);
    drain();
    chk("imp45_count", outs.size(), 25);
    chk("imp45_out15", outs[15], 16);
    chk("imp45_out14", outs[14], 0);
    chk("imp45_out16", outs[16], 0);
    apply_reset();
    for (int n = 0; n < 80; n++) send(n == 46 ? 31 : 0);
    drain();
    chk("imp46_out15", outs[15], 8);
    chk("imp46_out16", outs[16], 8);
    apply_reset();
    for (int n = 0; n < 80; n++) send(n == 44 ? 31 : 0);
    drain();
    chk("imp44_out14", outs[14], 8);
    chk("imp44_out15", outs[15], 8);

    // Random samples, random input gaps and random downstream readiness.
    apply_reset();
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      w = $urandom_range(0, 2);
      repeat (w) @(posedge clk);
      #1 send(int'($urandom_range(0, 63)) - 32);
    end
    drain();

    // Long downstream stall on every output.
    rdy_mode = 2;
    for (int n = 0; n < 30; n++) send(int'($urandom_range(0, 63)) - 32);
    drain();

    // Reset in the middle of MAC.
    rdy_mode = 0;
    apply_reset();
    for (int n = 0; n < 31; n++) send(int'($urandom_range(0, 63)) - 32);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_mac_rst_valid", valid_out0, 0);
    chk("mid_mac_rst_busy", busy0, 0);
    hist.delete(); exp_q.delete(); outs.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int n = 0; n < 40; n++) send(int'($urandom_range(0, 63)) - 32);
    drain();
    chk("post_rst_count", outs.size(), 5);

    // Reset while an output is being held.
    rdy_mode = 2;
    apply_reset();
    for (int n = 0; n < 31; n++) send(31);
    w = 0;
    while (!valid_out0 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("stall_valid_seen", valid_out0, 1);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_out_rst_valid", valid_out0, 0);
    chk("mid_out_rst_data", data_out0, 0);
    hist.delete(); exp_q.delete(); outs.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rdy_mode = 0;
    for (int n = 0; n < 35; n++) send(int'($urandom_range(0, 63)) - 32);
    drain();
    chk("post_out_rst_count", outs.size(), 3);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "global timeout");
  end

endmodule
